// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_s.sv
// Structural 1-bit full adder used as the time-shared datapath slice.

// Half adder cell.
module half_adder_s (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// Full adder from two half adders; either half-adder carry produces carry-out.
module full_adder_s (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0, c0, c1;

    half_adder_s u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
    half_adder_s u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

    assign c_o = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder slice reused LSB-first over N cycles,
// fronted by a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_defs::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int              CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     a_sr_q, a_sr_d;
    logic [N-1:0]     b_sr_q, b_sr_d;
    logic [N-1:0]     s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             fa_s, fa_co;

    full_adder_s u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: load on accept, one slice step per RUN cycle, capture on the last bit.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New sum bit enters at the MSB so the LSB-first stream lands in place.
                s_sr_d  = N'({fa_s, s_sr_q} >> 1);
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = N'({fa_s, s_sr_q} >> 1);
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: vector table + scoreboard for N=8, exhaustive sweep for N=2.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int done2_cnt = 0;

    logic [8:0] q8[$];
    logic [2:0] q2[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;
    vec_t tv[7];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboards: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) chk("unexpected_done8", 32'(done8), 32'd0);
            else chk("result8", 32'({cout8, sum8}), 32'(q8.pop_front()));
        end
        if (done2 === 1'b1) begin
            done2_cnt++;
            if (q2.size() == 0) chk("unexpected_done2", 32'(done2), 32'd0);
            else chk("result2", 32'({cout2, sum2}), 32'(q2.pop_front()));
        end
    end

    // One N=8 operation from IDLE: checks busy, latency, pulse width and hold.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] exp);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        chk("busy_after_accept", 32'(busy8), 32'd1);
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency8", 32'(lat), 32'd8);
        @(negedge clk);
        chk("done_one_cycle", 32'(done8), 32'd0);
        chk("busy_cleared", 32'(busy8), 32'd0);
        repeat (2) @(negedge clk);
        chk("result_held", 32'({cout8, sum8}), 32'(exp));
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int lat;
        @(negedge clk);
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        q2.push_back(3'(a) + 3'(b) + 3'(c));
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        lat = 0;
        while (done2 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency2", 32'(lat), 32'd2);
        @(negedge clk);
    endtask

    initial begin
        tv[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tv[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tv[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset with start asserted and random operands: reset must win.
        rst = 1'b1; start8 = 1'b1; start2 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy8), 32'd0);
            chk("rst_done", 32'(done8), 32'd0);
            chk("rst_sum", 32'(sum8), 32'd0);
            chk("rst_cout", 32'(cout8), 32'd0);
        end
        chk("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0; start8 = 1'b0; start2 = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done8 === 1'b1 || busy8 === 1'b1) seen++;
            end
            chk("idle_after_rst", 32'(seen), 32'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < 7; i++)
            op8(tv[i].a, tv[i].b, tv[i].cin, {tv[i].cout, tv[i].sum});

        // Start held high, operands churning: accepts land every N+2 edges.
        for (int k = 0; k < 40; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start8 = 1'b1;
            if (k % 10 == 0) q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            @(negedge clk);
            chk("cont_done_timing", 32'(done8), 32'((k % 10) == 8));
        end
        start8 = 1'b0;
        @(negedge clk);
        chk("cont_queue_drained", 32'(q8.size()), 32'd0);

        // Known nonzero result before the aborted operation.
        op8(8'h12, 8'h34, 1'b0, 9'h046);

        // Reset on the 4th RUN edge discards the operation.
        a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_sum", 32'(sum8), 32'd0);
        chk("midrst_cout", 32'(cout8), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done8 === 1'b1) seen++;
            end
            chk("midrst_no_done", 32'(seen), 32'd0);
        end
        op8(8'h10, 8'h20, 1'b0, 9'h030);

        // N=2 exhaustive sweep.
        done2_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            op2(v[4:3], v[2:1], v[0]);
        end
        chk("done2_count", 32'(done2_cnt), 32'd32);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares a single 1-bit full-adder slice over N clock cycles.
- Sequences operand loading, LSB-first shifting, carry storage and result capture behind a start/busy/done handshake.
- Serves as the sequential counterpart to the combinational half/full adder cells in the basic combinational-logic library.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 1.
- CNT_W, (N>1)?$clog2(N):1, width of the internal bit counter; derived, do not override.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  N  operand A; captured on the accept edge.
- b  input  N  operand B; captured on the accept edge.
- cin  input  1  carry-in; captured on the accept edge.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  N  registered result; held until the next result is written.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry flop and counter all 0.
- States:
  - IDLE: start=1 at an edge loads a_sr<=a, b_sr<=b, carry<=cin and cnt<=0, then moves to RUN. start=0 stays in IDLE.
  - RUN: every edge applies the full-adder slice to a_sr[0], b_sr[0] and carry.
    - Slice outputs: s = a^b^c and co = majority(a,b,c).
    - carry<=co; s_sr<={s, s_sr[N-1:1]}; a_sr and b_sr shift right with 0 filled in; cnt<=cnt+1.
    - When cnt==N-1: sum<={s, s_sr[N-1:1]}, cout<=co, done<=1, then move to DONE. No other state changes sum/cout.
  - DONE: lasts exactly one cycle with done=1. The next edge sets done<=0 and moves to IDLE.
- Latency: if start is sampled at edge T0, RUN spans edges T1..TN, and done is high for the single cycle after edge TN.
- Next accept edge is TN+2 at the earliest, so one operation completes per N+2 cycles.
- start while in RUN or DONE is ignored; it is not queued.
- a, b and cin changing after the accept edge have no effect on the operation in flight.
- Arithmetic is unsigned, {cout,sum} = a + b + cin (N+1 bits), and wrap-around is exact.
- N=1: a single RUN cycle; cnt==0 is the terminal condition.
- rst mid-operation: on the next edge the block returns to IDLE with all outputs at reset values. done does not pulse and the partial result is discarded.
- rst and start high together: rst wins and the start is not accepted.
- All outputs are registered; none are driven combinationally from inputs.

Decomposition:
- Shared package/header serial_adder_defs:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The CNT_W derivation.
- One sub-module, full_adder_s:
  - Structural 1-bit full adder built from two half_adder_s instances plus an OR gate for carry.
  - Instantiated once as the shared datapath slice.
- Everything else (FSM, shift registers, counter, output regs) is inline in serial_adder_ctrl.

Test Plan:
- Reset check: rst=1 for 2 cycles with random inputs → busy=0, done=0, sum=8'h00, cout=0; no done pulse afterward with start=0.
- Basic add: a=8'h3C, b=8'h05, cin=0, start pulsed 1 cycle.
  - busy=1 the cycle after the accept edge.
  - done high exactly 1 cycle, 8 edges after acceptance.
  - sum=8'h41, cout=0; sum/cout held until the next done.
- Carry cases:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Continuous start with operands changed every cycle during RUN.
  - Operations complete every 10 cycles.
  - Each result equals a+b+cin sampled at its accept edge.
  - Starts during RUN/DONE are ignored.
- Mid-operation reset: rst=1 on the 4th RUN edge.
  - Next cycle: IDLE, busy=0, sum=0, cout=0, no done pulse.
  - A following op with a=8'h10, b=8'h20 → sum=8'h30.
- Exhaustive: N=2, all 32 {a,b,cin} combinations → {cout,sum} matches reference model a+b+cin; done once per operation.
